// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Holds the FSM state encoding, default widths and the word-alignment check.
package mem_arb_pkg;

   localparam int MEM_AW   = 32;
   localparam int MEM_DW   = 32;
   localparam int STREAK_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BUSY_I   = 3'd1,
      ST_BUSY_D   = 3'd2,
      ST_RESP_I   = 3'd3,
      ST_RESP_D   = 3'd4,
      ST_RESP_ERR = 3'd5
   } arb_state_t;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_arb_fair_cnt.sv
// Counts consecutive data grants taken while a fetch was waiting.
// at_limit tells the arbiter to hand the next slot to the fetch side.
module mem_arb_fair_cnt
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_d,
   input  logic grant_i,
   input  logic i_pending,
   output logic at_limit
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX_D_STREAK);

   logic [STREAK_W-1:0] streak;

   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (grant_i) begin
         streak <= '0;
      end else if (grant_d) begin
         // Only data wins that made a fetch wait extend the streak.
         if (!i_pending) begin
            streak <= '0;
         end else if (streak < LIMIT) begin
            streak <= streak + STREAK_W'(1);
         end
      end
   end

   assign at_limit = (streak == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data has priority; a fairness counter bounds how long fetch can starve.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = MEM_AW,
   parameter int DW           = MEM_DW,
   parameter int MAX_D_STREAK = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_req_i,
   input  logic [AW-1:0] i_addr_i,
   output logic          i_ack_o,
   output logic [DW-1:0] i_rdata_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_ack_o,
   output logic [DW-1:0] d_rdata_o,
   output logic          d_err_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ack_i
);

   localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic          grant_i;
   logic          grant_d;
   logic          at_limit;
   logic          d_aligned;
   logic          busy;

   logic [AW-1:0] addr_p0;
   logic          we_p0;
   logic [DW-1:0] wdata_p0;
   logic [DW-1:0] rdata_p1;

   assign d_aligned = is_word_aligned(d_addr_i[1:0]);
   assign busy      = (state == ST_BUSY_I) || (state == ST_BUSY_D);

   mem_arb_fair_cnt #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_fair_cnt (
      .clk       (clk_i),
      .rst       (rst_i),
      .grant_d   (grant_d),
      .grant_i   (grant_i),
      .i_pending (i_req_i),
      .at_limit  (at_limit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (d_req_i && !(i_req_i && at_limit)) begin
               grant_d   = 1'b1;
               state_nxt = d_aligned ? ST_BUSY_D : ST_RESP_ERR;
            end else if (i_req_i) begin
               grant_i   = 1'b1;
               state_nxt = ST_BUSY_I;
            end
         end
         ST_BUSY_I: begin
            if (mem_ack_i) state_nxt = ST_RESP_I;
         end
         ST_BUSY_D: begin
            if (mem_ack_i) state_nxt = ST_RESP_D;
         end
         ST_RESP_I, ST_RESP_D, ST_RESP_ERR: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Stage p0: request fields frozen at grant time
   always_ff @(posedge clk_i) begin
      if (grant_i) begin
         addr_p0  <= i_addr_i & WORD_MASK;
         we_p0    <= 1'b0;
         wdata_p0 <= '0;
      end else if (grant_d) begin
         addr_p0  <= d_addr_i & WORD_MASK;
         we_p0    <= d_we_i;
         wdata_p0 <= d_wdata_i;
      end
   end

   // Stage p1: memory read word captured on the completing handshake
   always_ff @(posedge clk_i) begin
      if (busy && mem_ack_i) begin
         rdata_p1 <= mem_rdata_i;
      end
   end

   always_comb begin
      i_ack_o     = 1'b0;
      i_rdata_o   = '0;
      d_ack_o     = 1'b0;
      d_rdata_o   = '0;
      d_err_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (state)
         ST_BUSY_I: begin
            mem_req_o  = 1'b1;
            mem_addr_o = addr_p0;
         end
         ST_BUSY_D: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_p0;
            mem_addr_o  = addr_p0;
            mem_wdata_o = wdata_p0;
         end
         ST_RESP_I: begin
            i_ack_o   = 1'b1;
            i_rdata_o = rdata_p1;
         end
         ST_RESP_D: begin
            d_ack_o   = 1'b1;
            d_rdata_o = we_p0 ? '0 : rdata_p1;
         end
         ST_RESP_ERR: begin
            d_ack_o = 1'b1;
            d_err_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_mem_port_arbiter;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        i_req_i;
   logic [31:0] i_addr_i;
   logic        i_ack_o;
   logic [31:0] i_rdata_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_ack_o;
   logic [31:0] d_rdata_o;
   logic        d_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAXS)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .i_req_i     (i_req_i),
      .i_addr_i    (i_addr_i),
      .i_ack_o     (i_ack_o),
      .i_rdata_o   (i_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_ack_o     (d_ack_o),
      .d_rdata_o   (d_rdata_o),
      .d_err_o     (d_err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory responder: fixed latency in directed mode, random acks otherwise
   logic        rand_on = 1'b0;
   int          lat = 1;
   int          wcnt = 0;
   logic [31:0] mem_word = '0;

   always @(negedge clk) begin
      if (rand_on) begin
         wcnt        = 0;
         mem_ack_i   = ($urandom_range(2) == 0);
         mem_rdata_i = $urandom;
      end else begin
         mem_rdata_i = mem_word;
         if (mem_req_o) begin
            if (wcnt >= lat) begin
               mem_ack_i = 1'b1;
               wcnt      = 0;
            end else begin
               mem_ack_i = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
         end
      end
   end

   // Transaction-level model: who owns memory, which reply is due, fairness tally
   int          m_owner = 0;   // 0 none, 1 fetch, 2 data
   int          m_reply = 0;   // 0 none, 1 fetch, 2 data, 3 data error
   int          m_streak = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_word = '0;
   logic        m_we = 1'b0;

   always @(posedge clk) begin
      if (rst_i) begin
         m_owner  = 0;
         m_reply  = 0;
         m_streak = 0;
      end else if (m_reply != 0) begin
         m_reply = 0;
      end else if (m_owner != 0) begin
         if (mem_ack_i) begin
            m_word  = mem_rdata_i;
            m_reply = m_owner;
            m_owner = 0;
         end
      end else if (d_req_i && !(i_req_i && m_streak == MAXS)) begin
         m_streak = i_req_i ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         m_we     = d_we_i;
         if (d_addr_i % 4 != 0) begin
            m_reply = 3;
         end else begin
            m_owner = 2;
            m_addr  = d_addr_i;
            m_wdata = d_wdata_i;
         end
      end else if (i_req_i) begin
         m_streak = 0;
         m_owner  = 1;
         m_addr   = i_addr_i - (i_addr_i % 4);
      end
   end

   logic chk_on = 1'b0;

   always @(negedge clk) begin
      logic [132:0] act;
      logic [132:0] exp;
      if (chk_on) begin
         act = {i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, d_err_o,
                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
         exp = {(m_reply == 1), ((m_reply == 1) ? m_word : 32'h0),
                (m_reply >= 2), ((m_reply == 2 && !m_we) ? m_word : 32'h0),
                (m_reply == 3), (m_owner != 0), (m_owner == 2 && m_we),
                ((m_owner != 0) ? m_addr : 32'h0),
                ((m_owner == 2) ? m_wdata : 32'h0)};
         chk("cycle_outputs", 160'(act), 160'(exp));
      end
   end

   // Observations gathered while waiting for an ack
   logic [31:0] o_first_addr;
   logic [31:0] o_wdata;
   logic        o_we;
   logic        o_addr_stable;
   int          o_req_cycles;
   int          change_at = 0;
   logic [31:0] change_val = '0;

   task automatic wait_ack(input string tag, input int bound, output int which, output int cyc,
                           output logic [31:0] rdata, output logic err);
      which = 0; cyc = 0; rdata = '0; err = 1'b0;
      o_first_addr = '0; o_wdata = '0; o_we = 1'b0; o_addr_stable = 1'b1; o_req_cycles = 0;
      for (int k = 1; k <= bound; k++) begin
         @(negedge clk);
         if (mem_req_o) begin
            if (o_req_cycles == 0) o_first_addr = mem_addr_o;
            else if (mem_addr_o != o_first_addr) o_addr_stable = 1'b0;
            o_req_cycles++;
            o_we    = o_we | mem_we_o;
            o_wdata = mem_wdata_o;
         end
         if (k == change_at) i_addr_i = change_val;
         if (i_ack_o || d_ack_o) begin
            which = i_ack_o ? 1 : 2;
            cyc   = k;
            rdata = i_ack_o ? i_rdata_o : d_rdata_o;
            err   = d_err_o;
            break;
         end
      end
      if (which == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: no ack within %0d cycles", tag, bound);
      end
   endtask

   initial begin
      int          which, cyc, cnt;
      logic [31:0] rdata;
      logic        err;
      int          exp_order [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

      rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
      d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_on = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 160'({i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, d_err_o,
                                 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 160'(0));
      rst_i = 1'b0;
      @(negedge clk);

      // 1: lone fetch
      i_req_i = 1'b1; i_addr_i = 32'h10; lat = 1; mem_word = 32'h2010000A;
      wait_ack("t1", 20, which, cyc, rdata, err);
      chk("t1_who", which, 1);
      chk("t1_rdata", rdata, 32'h2010000A);
      chk("t1_mem_addr", o_first_addr, 32'h10);
      chk("t1_mem_we", o_we, 0);
      chk("t1_latency", cyc, 3);
      i_req_i = 1'b0;
      @(negedge clk);
      chk("t1_one_pulse", {i_ack_o, d_ack_o}, 0);

      // 2: simultaneous requests, store wins
      i_req_i = 1'b1; i_addr_i = 32'h30; d_req_i = 1'b1; d_we_i = 1'b1;
      d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF; lat = 0; mem_word = 32'h11112222;
      wait_ack("t2d", 20, which, cyc, rdata, err);
      chk("t2_first_who", which, 2);
      chk("t2_store_rdata", rdata, 0);
      chk("t2_mem_we", o_we, 1);
      chk("t2_mem_wdata", o_wdata, 32'hDEADBEEF);
      chk("t2_mem_addr", o_first_addr, 32'h20);
      d_req_i = 1'b0;
      wait_ack("t2i", 20, which, cyc, rdata, err);
      chk("t2_second_who", which, 1);
      chk("t2_fetch_rdata", rdata, 32'h11112222);
      chk("t2_fetch_addr", o_first_addr, 32'h30);
      i_req_i = 1'b0;
      @(negedge clk);

      // 3: continuous contention exercises the fairness limit
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40; i_req_i = 1'b1; i_addr_i = 32'h50;
      mem_word = 32'h0BADF00D;
      for (int g = 0; g < 10; g++) begin
         wait_ack("t3", 20, which, cyc, rdata, err);
         chk($sformatf("t3_grant%0d", g), which, exp_order[g]);
         if (g > 0) chk($sformatf("t3_spacing%0d", g), cyc, 3);
      end
      d_req_i = 1'b0; i_req_i = 1'b0;
      @(negedge clk);

      // 4: misaligned load
      d_req_i = 1'b1; d_addr_i = 32'h22; d_we_i = 1'b0;
      wait_ack("t4", 10, which, cyc, rdata, err);
      chk("t4_who", which, 2);
      chk("t4_err", err, 1);
      chk("t4_rdata", rdata, 0);
      chk("t4_latency", cyc, 1);
      chk("t4_no_mem_req", o_req_cycles, 0);
      d_req_i = 1'b0;
      @(negedge clk);
      chk("t4_one_pulse", {d_ack_o, d_err_o, mem_req_o}, 0);

      // 5: long memory latency with the fetch address wiggling
      i_req_i = 1'b1; i_addr_i = 32'h60; lat = 5; mem_word = 32'hCAFE0060;
      change_at = 2; change_val = 32'h64;
      wait_ack("t5", 30, which, cyc, rdata, err);
      chk("t5_who", which, 1);
      chk("t5_rdata", rdata, 32'hCAFE0060);
      chk("t5_req_cycles", o_req_cycles, 6);
      chk("t5_addr_stable", o_addr_stable, 1);
      chk("t5_addr", o_first_addr, 32'h60);
      i_req_i = 1'b0; change_at = 0;
      @(negedge clk);

      // 6: reset abandons an in-flight load
      d_req_i = 1'b1; d_addr_i = 32'h80; d_we_i = 1'b0; lat = 1000;
      repeat (3) @(negedge clk);
      chk("t6_busy", mem_req_o, 1);
      rst_i = 1'b1; d_req_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      chk("t6_req_dropped", {mem_req_o, d_ack_o}, 0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         cnt += int'(d_ack_o) + int'(mem_req_o);
      end
      chk("t6_quiet", cnt, 0);
      lat = 1; mem_word = 32'h0000ABCD; i_req_i = 1'b1; i_addr_i = 32'h04;
      wait_ack("t6", 20, which, cyc, rdata, err);
      chk("t6_who", which, 1);
      chk("t6_rdata", rdata, 32'h0000ABCD);
      chk("t6_addr", o_first_addr, 32'h04);
      i_req_i = 1'b0;
      @(negedge clk);

      // Randomized traffic, checked cycle by cycle against the model
      rand_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (rst_i) begin
            rst_i = 1'b0;
         end else if ($urandom_range(499) == 0) begin
            rst_i = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0;
         end else begin
            if (!i_req_i || i_ack_o) begin
               i_req_i  = ($urandom_range(3) != 0);
               i_addr_i = $urandom;
            end
            if (!d_req_i || d_ack_o) begin
               d_req_i   = ($urandom_range(2) != 0);
               d_we_i    = $urandom_range(1);
               d_addr_i  = $urandom;
               if ($urandom_range(5) != 0) d_addr_i[1:0] = 2'b00;
               d_wdata_i = $urandom;
            end
         end
      end
      i_req_i = 1'b0; d_req_i = 1'b0; rst_i = 1'b0;
      rand_on = 1'b0; lat = 1;
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
